// File: rtl/mux_arbiter.sv
// Round-robin arbiter for a 4:1 register mux with hold limit.
// Ownership is registered; one GAP cycle separates owners.
module mux_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] selecM,
  output logic       valid,
  output logic       forced
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam logic [7:0] HOLD = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       forced_q, forced_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;

  logic [1:0] win;
  logic [1:0] idx;
  logic       found;

  // Search starts just after the last owner, so it is tried last.
  always_comb begin
    win   = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i < 5; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    forced_d = 1'b0;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (found) begin
          state_d = BUSY;
          grant_d = 4'b0001 << win;
          sel_d   = {win[0], win[1]};
          valid_d = 1'b1;
          cnt_d   = 8'd1;
          ptr_d   = win;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (req[ptr_q] && cnt_q < HOLD) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          state_d  = GAP;
          grant_d  = '0;
          valid_d  = 1'b0;
          cnt_d    = '0;
          forced_d = req[ptr_q];
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      sel_q    <= 2'b00;
      valid_q  <= 1'b0;
      forced_q <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= 2'd3;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      forced_q <= forced_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant  = grant_q;
  assign selecM = sel_q;
  assign valid  = valid_q;
  assign forced = forced_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter, MAX_HOLD=8 and MAX_HOLD=1.
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] grant0, grant1;
  logic [1:0] sel0, sel1;
  logic       valid0, valid1;
  logic       forced0, forced1;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.MAX_HOLD(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .req(req),
    .grant(grant0), .selecM(sel0),
    .valid(valid0), .forced(forced0)
  );

  mux_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req),
    .grant(grant1), .selecM(sel1),
    .valid(valid1), .forced(forced1)
  );

  typedef struct {
    logic [7:0] e0;
    logic [7:0] e1;
  } exp_t;

  exp_t q[$];

  // Reference: owner index (-1 = none), hold count, last owner,
  // gap flag, forced flag and last select code per instance.
  int         m_own[2];
  int         m_cnt[2];
  int         m_ptr[2];
  bit         m_gap[2];
  bit         m_frc[2];
  logic [1:0] m_sel[2];
  int         hold[2] = '{8, 1};
  logic [1:0] code[4] = '{2'b00, 2'b10, 2'b01, 2'b11};

  function automatic int rr(input int p, input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1;
      m_cnt[k] = 0;
      m_ptr[k] = 3;
      m_gap[k] = 0;
      m_frc[k] = 0;
      m_sel[k] = 2'b00;
    end
  endtask

  task automatic m_step(input int k, input logic [3:0] r);
    int w;
    m_frc[k] = 0;
    if (m_own[k] < 0) begin
      m_gap[k] = 0;
      w = rr(m_ptr[k], r);
      if (w >= 0) begin
        m_own[k] = w;
        m_ptr[k] = w;
        m_cnt[k] = 1;
        m_sel[k] = code[w];
      end
    end else if (r[m_own[k]] && m_cnt[k] < hold[k]) begin
      m_cnt[k]++;
    end else begin
      m_frc[k] = r[m_own[k]];
      m_own[k] = -1;
      m_gap[k] = 1;
      m_cnt[k] = 0;
    end
  endtask

  function automatic logic [7:0] m_out(input int k);
    logic [3:0] g;
    g = (m_own[k] >= 0) ? 4'(1 << m_own[k]) : 4'b0000;
    return {g, m_sel[k], m_own[k] >= 0, m_frc[k]};
  endfunction

  task automatic apply(input logic [3:0] r);
    exp_t e;
    req = r;
    m_step(0, r);
    m_step(1, r);
    e.e0 = m_out(0);
    e.e1 = m_out(1);
    q.push_back(e);
  endtask

  task automatic step(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      apply(r);
    end
  endtask

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every edge with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("hold8", {grant0, sel0, valid0, forced0}, e.e0);
        check("hold1", {grant1, sel1, valid1, forced1}, e.e1);
      end
    end
  end

  initial begin
    logic [3:0] r;
    reset_n = 1'b0;
    req     = 4'b0000;
    m_reset();
    #12;
    check("rst0", {grant0, sel0, valid0, forced0}, 8'b0);
    check("rst1", {grant1, sel1, valid1, forced1}, 8'b0);

    @(negedge clk);
    reset_n = 1'b1;
    apply(4'b0000);

    step(4'b1111, 45);
    step(4'b0000, 3);
    step(4'b0100, 3);
    step(4'b0000, 4);
    step(4'b0010, 20);
    step(4'b0000, 3);
    step(4'b0100, 2);
    step(4'b1101, 1);
    step(4'b1001, 4);
    step(4'b0001, 3);
    step(4'b0000, 3);

    // Asynchronous reset in the 4th cycle of a grant.
    step(4'b1000, 4);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    q.delete();
    #1;
    check("async0", {grant0, sel0, valid0, forced0}, 8'b0);
    check("async1", {grant1, sel1, valid1, forced1}, 8'b0);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    apply(4'b0010);
    step(4'b0010, 3);
    step(4'b0000, 2);

    r = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      end
      step(r, 1);
    end

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
